// File: rtl/div_recon.sv
// Sequential reconstruction checker for sign-magnitude dividers: rebuilds |z|*|y|+|r| with a
// shift-add multiplier and flags mismatches against x. Optional early MUL exit: DIV_RECON_EARLY_EN.
module div_recon #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic [W-1:0]     z,
  input  logic [W-1:0]     r,
  output logic [W-1:0]     x_rec,
  output logic [2*W-3:0]   prod,
  output logic             ovf,
  output logic             dz,
  output logic             err,
  output logic             done,
  output logic             busy
);

  localparam int MW = W - 1;
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_acc;
  logic [MW-1:0]   r_xmag, r_ymag, r_zmag, r_rmag;
  logic            r_xs, r_ys, r_zs, r_rs;

  logic [PW-1:0]   w_add;
  logic            w_last;
  logic [PW-1:0]   w_prod;
  logic            w_pz, w_rz, w_qsign, w_sign, w_ovf, w_dz, w_sf, w_err;

  // Multiplier step and end-of-MUL detection
  always_comb begin
    w_add = '0;
    if (r_zmag[r_cnt])
      w_add = PW'(r_ymag) << r_cnt;
`ifdef DIV_RECON_EARLY_EN
    w_last = (r_cnt == CW'(MW - 1)) || ((r_zmag >> (r_cnt + CW'(1))) == '0);
`else
    w_last = (r_cnt == CW'(MW - 1));
`endif
  end

  // Final reconstruction; a zero product carries no sign so +0 and -0 compare equal
  always_comb begin
    w_prod  = r_acc + PW'(r_rmag);
    w_pz    = (w_prod == '0);
    w_rz    = (r_rmag == '0);
    w_qsign = r_zs ^ r_ys;
    w_sign  = 1'b0;
    if (!w_pz)
      w_sign = w_rz ? w_qsign : r_rs;
    w_ovf   = |w_prod[PW-1:MW];
    w_dz    = (r_ymag == '0);
    w_sf    = (!w_pz && (w_sign != r_xs)) ||
              ((r_zmag != '0) && !w_rz && (r_rs != w_qsign));
    w_err   = !w_dz && (w_ovf || (w_prod[MW-1:0] != r_xmag) || (r_rmag >= r_ymag) || w_sf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_xmag  <= '0;
      r_ymag  <= '0;
      r_zmag  <= '0;
      r_rmag  <= '0;
      r_xs    <= 1'b0;
      r_ys    <= 1'b0;
      r_zs    <= 1'b0;
      r_rs    <= 1'b0;
      x_rec   <= '0;
      prod    <= '0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            {r_xs, r_xmag} <= x;
            {r_ys, r_ymag} <= y;
            {r_zs, r_zmag} <= z;
            {r_rs, r_rmag} <= r;
            r_acc <= '0;
            r_cnt <= '0;
            busy  <= 1'b1;
`ifdef DIV_RECON_EARLY_EN
            r_state <= (z[MW-1:0] == '0) ? S_FIN : S_MUL;
`else
            r_state <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          r_acc <= r_acc + w_add;
          r_cnt <= r_cnt + CW'(1);
          if (w_last)
            r_state <= S_FIN;
        end
        S_FIN: begin
          prod    <= w_prod;
          x_rec   <= {w_sign, w_prod[MW-1:0]};
          ovf     <= w_ovf;
          dz      <= w_dz;
          err     <= w_err;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_recon.sv
// Randomised self-checking bench for div_recon against an arithmetic reference model.
module tb_div_recon;

  logic        clk, rst, start;
  logic [7:0]  x, y, z, r;
  logic [7:0]  x_rec;
  logic [13:0] prod;
  logic        ovf, dz, err, done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  div_recon #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x(x), .y(y), .z(z), .r(r),
    .x_rec(x_rec), .prod(prod), .ovf(ovf), .dz(dz), .err(err),
    .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected latency from the start edge to the cycle done is seen
  function automatic int exp_lat(input logic [7:0] zz);
    int k;
    k = 0;
    for (int i = 0; i < 7; i++)
      if (zz[i]) k = i + 1;
`ifdef DIV_RECON_EARLY_EN
    return k + 1;
`else
    return 8;
`endif
  endfunction

  task automatic check_res(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    int xm, ym, zm, rm, p, s, qs, xr, e_ovf, e_dz, sf, e_err;
    xm = a & 127; ym = b & 127; zm = c & 127; rm = d & 127;
    qs = c[7] ^ b[7];
    p  = zm * ym + rm;
    if (p == 0)       s = 0;
    else if (rm != 0) s = d[7];
    else              s = qs;
    xr    = s * 128 + (p % 128);
    e_ovf = (p > 127);
    e_dz  = (ym == 0);
    sf    = ((p != 0) && (s != a[7])) || ((zm != 0) && (rm != 0) && (d[7] != qs));
    e_err = !e_dz && (e_ovf || ((p % 128) != xm) || (rm >= ym) || (sf != 0));
    chk({tag, ".prod"}, prod, p);
    chk({tag, ".x_rec"}, x_rec, xr);
    chk({tag, ".ovf"}, ovf, e_ovf);
    chk({tag, ".dz"}, dz, e_dz);
    chk({tag, ".err"}, err, e_err);
  endtask

  // Launch one op, scramble inputs after the start edge, wait for done and check
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
    int lat;
    @(negedge clk);
    x = a; y = b; z = c; r = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom); z = 8'($urandom); r = 8'($urandom);
    chk({tag, ".busy_e0"}, busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!done && busy !== 1'b1) chk({tag, ".busy_mid"}, busy, 1);
    end
    chk({tag, ".latency"}, lat, exp_lat(c));
    chk({tag, ".busy_done"}, busy, 0);
    check_res(tag, a, b, c, d);
  endtask

  initial begin
    int ndone;
    int ym, zm, rm, xs;
    logic [7:0] a, b, c, d;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; z = '0; r = '0;
    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.prod", prod, 0);
    chk("rst.x_rec", x_rec, 0);
    @(negedge clk); rst = 1'b0;

    run_op("s1", 8'h64, 8'h07, 8'h0E, 8'h02);
    chk("s1.prod_const", prod, 100);
    chk("s1.xrec_const", x_rec, 8'h64);
    run_op("s2", 8'hE4, 8'h07, 8'h8E, 8'h82);
    chk("s2.xrec_const", x_rec, 8'hE4);
    run_op("s2b", 8'hE4, 8'h07, 8'h8E, 8'h03);
    chk("s2b.err_const", err, 1);
    run_op("s3", 8'h00, 8'h7F, 8'h7F, 8'h00);
    chk("s3.prod_const", prod, 16129);
    run_op("s3b", 8'h00, 8'h7F, 8'h7F, 8'h7F);
    chk("s3b.prod_const", prod, 16256);
    run_op("s4", 8'h01, 8'h80, 8'h05, 8'h01);
    chk("s4.dz_const", dz, 1);
    run_op("e1", 8'h05, 8'h05, 8'h01, 8'h00);
    run_op("e0", 8'h03, 8'h05, 8'h00, 8'h03);

    // Reset in the middle of an operation
    @(negedge clk);
    x = 8'h64; y = 8'h07; z = 8'h0E; r = 8'h02; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    chk("mrst.busy", busy, 0);
    chk("mrst.prod", prod, 0);
    chk("mrst.x_rec", x_rec, 0);
    chk("mrst.err", err, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done) ndone++; end
    chk("mrst.no_done", ndone, 0);
    run_op("s1r", 8'h64, 8'h07, 8'h0E, 8'h02);

    // Start while busy must be ignored
    @(negedge clk);
    x = 8'h00; y = 8'h7F; z = 8'h7F; r = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    x = 8'h64; y = 8'h07; z = 8'h0E; r = 8'h02; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    repeat (20) begin @(posedge clk); #1; if (done) ndone++; end
    chk("sbusy.ndone", ndone, 1);
    check_res("sbusy", 8'h00, 8'h7F, 8'h7F, 8'h00);

    // Random operations: half consistent divisions, half arbitrary
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        ym = $urandom_range(1, 127);
        zm = $urandom_range(0, 127 / ym);
        rm = $urandom_range(0, ((127 - zm * ym) < (ym - 1)) ? (127 - zm * ym) : (ym - 1));
        xs = $urandom_range(0, 1);
        b = 8'(($urandom_range(0, 1) << 7) | ym);
        c = 8'(((xs ^ b[7]) << 7) | zm);
        d = 8'((xs << 7) | rm);
        a = 8'((xs << 7) | (zm * ym + rm));
      end else begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      end
      run_op($sformatf("rnd%0d", i), a, b, c, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_recon.md
Name: div_recon

Overview:
- Sequential checker for the 8-bit sign-magnitude dividers.
- Takes dividend x, divisor y, quotient z and remainder r, and rebuilds the dividend as |z|*|y| + |r| using a shift-add multiplier. It then compares the rebuilt value against x and flags errors.
- Sits beside the divider pair and consumes their z/r outputs after busy falls. It is the inverse (multiply) direction of the divide datapath.

Parameters:
- W, 8: operand width, sign-magnitude (bit W-1 = sign, W-2:0 = magnitude).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x  in  8  original dividend (sign-magnitude).
- y  in  8  divisor.
- z  in  8  quotient under test.
- r  in  8  remainder under test.
- x_rec  out  8  rebuilt dividend (sign-magnitude).
- prod  out  14  full magnitude |z|*|y| + |r|.
- ovf  out  1  prod exceeds 7-bit magnitude.
- dz  out  1  divisor magnitude zero; check skipped.
- err  out  1  reconstruction mismatch.
- done  out  1  one-cycle pulse, results valid.
- busy  out  1  operation in progress.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1, all state and outputs are 0 and the FSM is in IDLE.
- FSM states: IDLE, MUL, FIN.
- IDLE:
  - start=1 at edge E0 latches x, y, z, r.
  - Clears the 14-bit accumulator and the 3-bit counter.
  - Sets busy=1 and goes to MUL.
- MUL: one multiplier bit per cycle, LSB first.
  - If the current bit of |z| is 1, acc += |y| << cnt.
  - cnt increments each cycle.
  - After 7 cycles (edges E1..E7), go to FIN.
- FIN (edge E8):
  - prod = acc + |r|. The maximum is 127*127 + 127 = 16256, which fits in 14 bits with no wrap.
  - x_rec[6:0] = prod[6:0].
  - x_rec[7] = 0 if prod==0; else r[7] if |r|!=0; else z[7]^y[7].
  - ovf = |prod[13:7].
  - dz = (|y|==0).
  - err = !dz & (ovf | (x_rec[6:0] != |x|) | (|r| >= |y|) | sign fault).
  - Sign fault: prod!=0 and x_rec[7]!=x[7], or (|z|!=0 & |r|!=0 & r[7]!=z[7]^y[7]).
  - Zero magnitudes compare equal regardless of sign bit (+0 == -0).
  - Sets done=1 for exactly the cycle after E8, busy=0, returns to IDLE.
- Outputs x_rec/prod/ovf/dz/err hold until the next FIN or reset.
- busy is high from E0 through E8: 8 cycles. Latency from start to done is 8 cycles.
- start while busy: ignored, with no effect on the current operation.
- start in the same cycle done is high: accepted, since the FSM is already in IDLE.
- Input changes after E0 have no effect (operands are latched).
- Reset mid-operation: abort immediately; done never pulses for the aborted op and result outputs go to 0. The next start after rst falls behaves normally.
- dz=1: err forced 0; prod and x_rec are still computed.

Optional Feature:
- Macro DIV_RECON_EARLY_EN.
- Defined: MUL exits when the remaining unshifted bits of |z| are all zero. MUL runs k cycles, k = (index of MSB set in |z|) + 1, or 0 when |z|==0 (IDLE goes straight to FIN). done follows edge E(k+1). Results are identical to the non-early case.
- Undefined: fixed 7 MUL cycles and 8-cycle latency, as above.

Test Plan:
- x=0x64, y=0x07, z=0x0E, r=0x02 (+100 = 7*14 + 2), start one cycle -> busy high 8 cycles; done pulse after E8; prod=100, x_rec=0x64, err=0, ovf=0, dz=0.
- x=0xE4, y=0x07, z=0x8E, r=0x82 (-100) -> x_rec=0xE4, err=0. Then repeat with r=0x03 (positive) -> x_rec[6:0]=0x65, err=1.
- x=0x00, y=0x7F, z=0x7F, r=0x00 -> prod=16129 (0x3F01), ovf=1, err=1. With r=0x7F -> prod=16256, err=1 (also |r|>=|y|).
- y=0x80 (-0), z=0x05, r=0x01 -> dz=1, err=0, prod=1.
- Start a valid op, assert rst at cycle 4 for 1 cycle -> busy=0 and outputs 0 immediately, no done. Then restart scenario 1 -> correct result after 8 cycles. Also pulse start again at cycle 3 of an op -> ignored, single done.
- With DIV_RECON_EARLY_EN: z=0x01, y=0x05, r=0x00, x=0x05 -> done after 2 cycles (k=1), x_rec=0x05. z=0x00, r=0x03, y=0x05, x=0x03 -> done after 1 cycle (k=0), x_rec=0x03.
